seq_detect_ctrl: RTL

- Programmable serial sequence-detector controller: accepts a pattern configuration over a valid/ready handshake, arms on start, matches the din bit stream, counts hits and finishes on target count, timeout or abort.
- Sits between the FSM-problems serial detectors' bit source and any consumer that needs match pulses plus completion status.

---
 rtl/seq_detect_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Purpose  : Programmable serial sequence-detector controller. A pattern
//            configuration is accepted over a valid/ready handshake. start
//            arms the detector, which then matches the din bit stream, counts
//            hits and finishes on a target count, a timeout or an abort.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   cfg_valid     configuration offered
//   cfg_ready     configuration accepted (IDLE / CONFIGURED only)
//   cfg_pattern   pattern, bit[len-1] is received first, bit0 last
//   cfg_len       pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//   cfg_overlap   1 = overlapping matches allowed
//   cfg_target    hits to collect, 0 = unlimited
//   cfg_timeout   max ARMED cycles without a hit, 0 = disabled
//   start         arm request (honoured in CONFIGURED)
//   abort         cancel an armed run
//   din           serial data bit
//   din_valid     din qualifier
//   detected      one-cycle match pulse (one cycle after the sampling edge)
//   match_count   hits in the current run, saturating
//   busy          high while ARMED
//   done          one-cycle pulse when the target count is reached
//   timeout_flag  sticky timeout indication, cleared by the next start
// ============================================================================
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               din,
  input  logic               din_valid,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               timeout_flag
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_cfg   = 3'd1;
  localparam logic [2:0] c_st_armed = 3'd2;
  localparam logic [2:0] c_st_done  = 3'd3;
  localparam logic [2:0] c_st_tmo   = 3'd4;

  localparam logic [3:0] c_len_max = 4'(MAX_LEN);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]         r_state;
  logic [2:0]         w_state_n;

  logic [MAX_LEN-1:0] r_pattern;
  logic [3:0]         r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target;
  logic [TO_W-1:0]    r_timeout;

  logic [MAX_LEN-1:0] r_hist;
  logic [3:0]         r_fill;
  logic [TO_W-1:0]    r_tcnt;
  logic [CNT_W-1:0]   r_count;
  logic               r_detected;
  logic               r_tflag;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic               w_cfg_fire;
  logic               w_arm;
  logic               w_armed;
  logic               w_sample;
  logic [MAX_LEN-1:0] w_hist_n;
  logic [3:0]         w_fill_n;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic [CNT_W-1:0]   w_count_n;
  logic [TO_W-1:0]    w_tcnt_n;
  logic               w_target_hit;
  logic               w_tmo_hit;
  logic [3:0]         w_len_clamped;

  assign w_cfg_fire = cfg_valid & cfg_ready;
  assign w_arm      = (r_state == c_st_cfg) & start;
  assign w_armed    = (r_state == c_st_armed);
  // Abort wins over any bit sampled on the same edge, so it blocks sampling.
  assign w_sample   = w_armed & din_valid & ~abort;

  // Shift history: newest bit enters at bit0.
  generate
    if (MAX_LEN > 1) begin : g_hist_wide
      assign w_hist_n = {r_hist[MAX_LEN-2:0], din};
    end else begin : g_hist_narrow
      assign w_hist_n = din;
    end
  endgenerate

  // fill counts valid history bits, saturating at MAX_LEN.
  assign w_fill_n = (r_fill >= c_len_max) ? c_len_max : r_fill + 4'd1;

  // Mask selecting the low r_len bits of the history and pattern.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (4'(i) < r_len);
    end
  end

  assign w_hit = w_sample && (w_fill_n >= r_len)
              && (((w_hist_n ^ r_pattern) & w_mask) == '0);

  assign w_count_n    = (&r_count) ? r_count : r_count + 1'b1;
  assign w_tcnt_n     = (&r_tcnt)  ? r_tcnt  : r_tcnt + 1'b1;
  assign w_target_hit = w_hit && (r_target != '0) && (w_count_n == r_target);
  // A hit on the expiry edge restarts the idle count instead of timing out.
  assign w_tmo_hit    = w_armed && !abort && !w_hit && (r_timeout != '0)
                     && (w_tcnt_n == r_timeout);

  assign w_len_clamped = (cfg_len == 4'd0)      ? 4'd1      :
                         (cfg_len > c_len_max)  ? c_len_max : cfg_len;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_n;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_cfg_fire) w_state_n = c_st_cfg;
      end
      c_st_cfg: begin
        if (start) w_state_n = c_st_armed;
      end
      c_st_armed: begin
        if (abort)             w_state_n = c_st_cfg;
        else if (w_target_hit) w_state_n = c_st_done;
        else if (w_tmo_hit)    w_state_n = c_st_tmo;
      end
      c_st_done: w_state_n = c_st_cfg;
      c_st_tmo:  w_state_n = c_st_cfg;
      default:   w_state_n = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    cfg_ready    = (r_state == c_st_idle) || (r_state == c_st_cfg);
    busy         = (r_state == c_st_armed);
    done         = (r_state == c_st_done);
    detected     = r_detected;
    match_count  = r_count;
    timeout_flag = r_tflag;
  end

  // --------------------------------------------------------------------------
  // Configuration registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= '0;
      r_len     <= 4'd0;
      r_overlap <= 1'b0;
      r_target  <= '0;
      r_timeout <= '0;
    end else if (w_cfg_fire) begin
      r_pattern <= cfg_pattern;
      r_len     <= w_len_clamped;
      r_overlap <= cfg_overlap;
      r_target  <= cfg_target;
      r_timeout <= cfg_timeout;
    end
  end

  // --------------------------------------------------------------------------
  // Matching datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist     <= '0;
      r_fill     <= 4'd0;
      r_tcnt     <= '0;
      r_count    <= '0;
      r_detected <= 1'b0;
      r_tflag    <= 1'b0;
    end else begin
      r_detected <= w_hit;

      if (w_arm) begin
        r_hist  <= '0;
        r_fill  <= 4'd0;
        r_tcnt  <= '0;
        r_count <= '0;
        r_tflag <= 1'b0;
      end

      if (w_armed) begin
        r_tcnt <= w_hit ? '0 : w_tcnt_n;
      end

      if (w_sample) begin
        r_hist <= w_hist_n;
        // Without overlap a hit consumes its bits: the next match needs a
        // full fresh pattern.
        r_fill <= (w_hit && !r_overlap) ? 4'd0 : w_fill_n;
      end

      if (w_hit) begin
        r_count <= w_count_n;
      end

      if (w_tmo_hit) begin
        r_tflag <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
